// File: rtl/soc_pkg.sv
// Shared UART arbiter definitions: FSM state encoding and frame constants.
package soc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   localparam int UART_DIV_DEFAULT = 434;
   localparam int UART_FRAME_BITS  = 10;
   // Frame = start + data + stop, so data width falls out of the frame length.
   localparam int UART_DATA_BITS   = UART_FRAME_BITS - 2;

endpackage : soc_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first valid requester at or after i_ptr, with wrap.
module rr_arbiter
   import soc_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]         i_req_valid,
   input  logic [$clog2(NREQ)-1:0] i_ptr,
   output logic [NREQ-1:0]         o_grant,
   output logic [$clog2(NREQ)-1:0] o_grant_id,
   output logic                    o_grant_valid
);
   localparam int IW = $clog2(NREQ);

   logic [IW:0]   w_sum;
   logic [IW-1:0] w_idx;
   logic          w_hit;

   // Scan from the pointer upward; the first hit freezes the grant index.
   always_comb begin
      o_grant_id    = '0;
      o_grant_valid = 1'b0;
      w_sum         = '0;
      w_idx         = '0;
      w_hit         = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         w_sum = {1'b0, i_ptr} + (IW+1)'(k);
         // Explicit modulo keeps non-power-of-2 NREQ inside the valid range.
         w_idx = (w_sum >= (IW+1)'(NREQ)) ? IW'(w_sum - (IW+1)'(NREQ)) : w_sum[IW-1:0];
         w_hit = ~o_grant_valid & i_req_valid[w_idx];
         o_grant_id    = w_hit ? w_idx : o_grant_id;
         o_grant_valid = o_grant_valid | w_hit;
      end
      o_grant = o_grant_valid ? (NREQ'(1) << o_grant_id) : '0;
   end

endmodule : rr_arbiter

// File: rtl/uart_tx_arbiter.sv
// Round-robin shared 8N1 UART transmitter: one byte latched per grant, LSB first.
module uart_tx_arbiter
   import soc_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int CLK_DIV = UART_DIV_DEFAULT
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic [NREQ-1:0]         i_req_valid,
   input  logic [8*NREQ-1:0]       i_req_data,
   output logic [NREQ-1:0]         o_req_ready,
   output logic                    o_ser_tx,
   output logic                    o_busy,
   output logic [$clog2(NREQ)-1:0] o_grant_id
);
   localparam int IW = $clog2(NREQ);
   localparam int BW = $clog2(CLK_DIV);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
   localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);
   localparam logic [IW-1:0] ID_LAST   = IW'(NREQ - 1);

   uart_state_e   r_state,    w_state_next;
   logic [BW-1:0] r_baud,     w_baud_next;
   logic [2:0]    r_bit,      w_bit_next;
   logic [7:0]    r_shift,    w_shift_next;
   logic [IW-1:0] r_ptr,      w_ptr_next;
   logic [IW-1:0] r_grant_id, w_grant_id_next;
   logic          r_ser_tx,   w_ser_tx_next;
   logic          r_busy;

   logic [NREQ-1:0] w_grant;
   logic [IW-1:0]   w_grant_idx;
   logic            w_grant_any;
   logic            w_accept;
   logic            w_baud_wrap;
   logic [7:0]      w_req_byte;

   rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
      .i_req_valid   (i_req_valid),
      .i_ptr         (r_ptr),
      .o_grant       (w_grant),
      .o_grant_id    (w_grant_idx),
      .o_grant_valid (w_grant_any)
   );

   // Reset gates the handshake so no byte is taken while reset is asserted.
   assign w_accept    = (r_state == ST_IDLE) && !i_reset && w_grant_any;
   assign o_req_ready = w_accept ? w_grant : '0;
   assign w_req_byte  = i_req_data[8*int'(w_grant_idx) +: 8];
   assign w_baud_wrap = (r_baud == BAUD_LAST);

   // Next-state and next-output logic; ser_tx is computed one cycle ahead so the pin is registered.
   always_comb begin
      w_state_next    = r_state;
      w_baud_next     = r_baud;
      w_bit_next      = r_bit;
      w_shift_next    = r_shift;
      w_ptr_next      = r_ptr;
      w_grant_id_next = r_grant_id;
      w_ser_tx_next   = r_ser_tx;
      case (r_state)
         ST_IDLE: begin
            w_baud_next = '0;
            w_bit_next  = 3'd0;
            if (w_accept) begin
               w_state_next    = ST_START;
               w_shift_next    = w_req_byte;
               w_grant_id_next = w_grant_idx;
               w_ptr_next      = (w_grant_idx == ID_LAST) ? '0 : w_grant_idx + IW'(1);
               w_ser_tx_next   = 1'b0;
            end else begin
               w_ser_tx_next   = 1'b1;
            end
         end
         ST_START: begin
            if (w_baud_wrap) begin
               w_baud_next   = '0;
               w_state_next  = ST_DATA;
               w_bit_next    = 3'd0;
               w_ser_tx_next = r_shift[0];
            end else begin
               w_baud_next   = r_baud + BW'(1);
            end
         end
         ST_DATA: begin
            if (w_baud_wrap) begin
               w_baud_next = '0;
               if (r_bit == BIT_LAST) begin
                  w_state_next  = ST_STOP;
                  w_ser_tx_next = 1'b1;
               end else begin
                  w_bit_next    = r_bit + 3'd1;
                  w_shift_next  = {1'b0, r_shift[7:1]};
                  w_ser_tx_next = r_shift[1];
               end
            end else begin
               w_baud_next = r_baud + BW'(1);
            end
         end
         ST_STOP: begin
            if (w_baud_wrap) begin
               w_baud_next  = '0;
               w_state_next = ST_IDLE;
            end else begin
               w_baud_next  = r_baud + BW'(1);
            end
            w_ser_tx_next = 1'b1;
         end
         default: begin
            w_state_next  = ST_IDLE;
            w_baud_next   = '0;
            w_bit_next    = 3'd0;
            w_ser_tx_next = 1'b1;
         end
      endcase
   end

   // State, datapath and output registers; reset abandons any frame in flight.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_baud     <= '0;
         r_bit      <= 3'd0;
         r_shift    <= 8'd0;
         r_ptr      <= '0;
         r_grant_id <= '0;
         r_ser_tx   <= 1'b1;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_baud     <= w_baud_next;
         r_bit      <= w_bit_next;
         r_shift    <= w_shift_next;
         r_ptr      <= w_ptr_next;
         r_grant_id <= w_grant_id_next;
         r_ser_tx   <= w_ser_tx_next;
         r_busy     <= (w_state_next != ST_IDLE);
      end
   end

   assign o_ser_tx   = r_ser_tx;
   assign o_busy     = r_busy;
   assign o_grant_id = r_grant_id;

endmodule : uart_tx_arbiter

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the SoC's single UART transmit line between `NREQ` byte-stream requesters (CPU console, debug/status sources). It grants requesters round-robin, latches one byte per grant and serialises it as 8N1 at `clk / CLK_DIV` baud. Its output drives the top-level `Uart_Tx` pin in place of a private transmitter per source.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters, range 2..8.
- `CLK_DIV`, default 434: clock cycles per bit (50 MHz / 115200); must be ≥ 2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester byte available.
- `req_data`  in  8*NREQ  byte for requester i at bits [8i+7:8i].
- `req_ready`  out  NREQ  one-hot accept pulse; transfer occurs when `req_valid[i] & req_ready[i]`.
- `ser_tx`  out  1  serial line, idle high.
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE).
- `grant_id`  out  $clog2(NREQ)  index of the requester owning the current or last frame.

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE:
  - `ser_tx` = 1.
  - Arbiter selects the first `i` with `req_valid[i]`, searching from pointer `ptr` upward with wrap.
  - `req_ready[i]` asserts combinationally in that cycle only when in IDLE; all other bits are 0.
  - On the accept cycle:
    - latch `req_data[i]` into the shift register;
    - `grant_id` ← i;
    - `ptr` ← (i+1) mod NREQ;
    - go to START.
- START: `ser_tx` = 0 for `CLK_DIV` cycles, then DATA.
- DATA:
  - 8 bits, LSB first, each held `CLK_DIV` cycles.
  - Bit index counter is 0..7; after bit 7, go to STOP.
- STOP: `ser_tx` = 1 for `CLK_DIV` cycles, then IDLE.
- Handshake rules:
  - Requesters hold `req_valid` and `req_data` stable until accepted.
  - Deasserting `req_valid` before acceptance is allowed; the byte is simply not sent.
  - `req_ready` never asserts outside IDLE.
- Fairness: a continuously requesting source waits at most `NREQ-1` frames.
- Width rules:
  - Baud counter is $clog2(CLK_DIV) bits and counts 0..CLK_DIV-1; it wraps to 0 at each bit boundary.
  - `ptr` wraps modulo `NREQ`, including non-power-of-2 `NREQ`.
- Simultaneous requests: all valid in the same cycle → the one at or after `ptr` wins; the others stay pending.
- Reset values:
  - `ser_tx` = 1, `busy` = 0, `req_ready` = 0 during reset.
  - `grant_id` = 0, `ptr` = 0, state = IDLE, counters = 0.
- Reset mid-frame: the frame is abandoned and the latched byte dropped. `ser_tx` is high from the cycle after reset is sampled.

## Timing
- `ser_tx`, `busy`, `grant_id`: registered outputs. `req_ready`: combinational from state and `req_valid`.
- Accept at cycle T:
  - START bit on `ser_tx` from T+1;
  - data bit k from T+1+(k+1)·CLK_DIV;
  - STOP from T+1+9·CLK_DIV;
  - IDLE at T+1+10·CLK_DIV.
- Back-to-back frames: next accept is no earlier than T+1+10·CLK_DIV. The minimum frame period is 10·CLK_DIV+1 cycles, i.e. one idle-high cycle between frames.
- `busy` is high from T+1 through T+10·CLK_DIV inclusive.

## Structure
- Shared package `soc_pkg`:
  - state enum constants (IDLE/START/DATA/STOP);
  - `UART_DIV_DEFAULT` = 434;
  - `UART_FRAME_BITS` = 10.
- Sub-module `rr_arbiter`:
  - combinational grant from `req_valid` and `ptr`;
  - outputs a one-hot grant and an encoded index;
  - parameterised by `NREQ`.
- The top of this block holds the FSM, baud counter, bit counter, shift register and `ptr` register.

## Test plan
Simulation uses `CLK_DIV`=4.
- Single byte: after reset, `req_valid[0]`=1 with 8'hA5.
  - `req_ready[0]` pulses one cycle.
  - `ser_tx` shows 0, then 1,0,1,0,0,1,0,1, then 1, each 4 cycles.
  - `busy` is high 40 cycles; `grant_id`=0.
- Contention: both requesters hold valid continuously, 8'h11 and 8'h22.
  - Frames alternate 0,1,0,1 starting with 0; `grant_id` follows.
  - Frame starts are 41 cycles apart.
- Pointer wrap (NREQ=3): only requester 2 valid, then only requester 0 valid.
  - Both are served; `ptr` goes 0→0 after the first grant (2+1 mod 3), and requester 0 wins next even if 1 becomes valid in the same cycle.
- Withdrawn request: `req_valid[1]` pulses for 1 cycle while busy.
  - No `req_ready[1]`; no frame is sent for it.
- Reset mid-frame: assert `reset` at bit 3 of 8'h00.
  - `ser_tx`=1 next cycle; `busy`=0; `req_ready`=0.
  - After release, a pending `req_valid[1]` with 8'hFF is served with `grant_id`=1.
- Stability: hold `req_valid` with `req_data` unchanged during 5 consecutive frames from one source.
  - Exactly 5 accept pulses, each exactly 41 cycles apart.
